fwd_scoreboard: RTL and testbench
=================================

// Module: fwd_scoreboard
// PURPOSE
//  Parametrised EX-stage forwarding/hazard unit with an internal in-flight scoreboard.
//  Tracks every write-back instruction from EX to WB. Decides per source operand, one cycle
//  early in ID, which stage to forward from. Raises load-use/latency stalls itself.
//  Sits between ID decode and the EX operand muxes; also counts stall cycles.
// PARAMETERS
//  NSRC   2  source operands per instruction
//  NSTAGE 3  tracked stages after ID: index 0=EX, 1=MEM, ..., NSTAGE-1=WB
//  AW     5  register address width
//  LATW   2  width of per-op result latency field
//  SELW   $clog2(NSTAGE) forward-select width (derived localparam)
// PORTS
//  clk           in  1         clock
//  rst           in  1         synchronous reset, active-high
//  hold          in  1         global freeze (memory wait): scoreboard and outputs hold
//  flush         in  1         kill instruction currently in ID
//  id_valid      in  1         ID holds a real instruction
//  id_rs_addr    in  NSRC*AW   source addresses, operand i at [i*AW +: AW]
//  id_rs_used    in  NSRC      operand i is actually read
//  id_rd_addr    in  AW        destination address
//  id_reg_write  in  1         instruction writes rd
//  id_lat        in  LATW      first stage index whose output carries result (ALU=1, load=2)
//  stall         out 1         combinational: hold PC/ID, inject bubble into EX
//  fwd_sel_ex    out NSRC*SELW registered, aligned with EX: 0=regfile, k=stage index k
//  stall_cnt     out 32        saturating count of cycles with stall=1
// BEHAVIOUR
//  - Reset: all entries invalid, fwd_sel_ex=0, stall_cnt=0; stall forced 0 while rst=1.
//  - Entry fields: valid, rd, lat. Valid only if reg_write=1 and rd!=0.
//  - Advance (hold=0): entry[k] <= entry[k-1] for k=1..NSTAGE-1; the WB entry retires.
//  - Advance (hold=0), EX slot: entry[0] gets the ID instruction.
//    It gets a bubble instead if stall, flush or !id_valid.
//  - Operand i matches producer entry[j] (j=0..NSTAGE-2) when: entry valid,
//    id_rs_used[i], and rd==rs_i. Producer reaches index j+1 next cycle.
//  - Youngest match (smallest j) wins. Older matches are ignored even if ready.
//  - No match gives sel 0. Regfile is write-first, so a WB-stage write is read in the same cycle.
//  - Youngest match with lat <= j+1: fwd_sel_ex[i] <= j+1 on next advance.
//  - Youngest match with lat > j+1: hazard. stall=1 (if id_valid && !flush).
//    That operand's next sel is don't-care; bench checks it only when EX is not a bubble.
//  - stall = OR of hazards over all operands. Purely a function of ID inputs and entries;
//    depends on no other output.
//  - Bubble in EX (stall/flush/!id_valid): fwd_sel_ex <= 0 for all operands.
//  - Priority: rst > hold > flush > stall.
//    hold=1 freezes entries, fwd_sel_ex and stall_cnt; stall is still reported.
//    flush=1 suppresses stall and inserts a bubble.
//  - stall_cnt increments when stall && !hold; saturates at 32'hFFFF_FFFF.
//  - Reset mid-stall: next cycle all entries are empty, so a repeated ID instruction
//    proceeds without stalling.
//  - lat=0 is treated as lat=1. lat >= NSTAGE never forwards: the consumer stalls until
//    the producer retires and it reads the regfile.
// STRUCTURE
//  - Shared package pipe_pkg: SEL_REGFILE=0; LAT_ALU=1, LAT_LOAD=2; stage-index localparams.
//  - One sub-module: fwd_match.
//    Combinational, per operand: youngest-match priority encoder over NSTAGE-1 entries.
//    Returns {hit, idx, ready}. Instantiated NSRC times by generate.
//  - Top level holds: entry shift registers, fwd_sel_ex flops, stall OR, stall counter.
// TESTING (NSRC=2, NSTAGE=3)
//  1. Back-to-back ALU: add x5 (lat1), then sub x6,x5,x7.
//     -> stall=0; EX cycle of sub: fwd_sel_ex[0]=1 (MEM), [1]=0.
//  2. Load-use: lw x5 (lat2), then add x6,x5,x5.
//     -> stall=1 exactly one cycle, stall_cnt=1; then both sels=2 (WB).
//  3. Youngest wins: add x5; add x5; add x8,x5,x0.
//     -> sel[0]=1 (not 2); x0 source sel=0.
//  4. x0 and unused operand: producer writes x0, or rs_used=0.
//     -> never stalls, sel=0.
//  5. hold=1 for 3 cycles during a load-use stall.
//     -> entries/sels frozen, stall stays 1, stall_cnt unchanged.
//     After hold drops: 1 stall cycle counted.
//  6. flush with a hazard in ID -> stall=0, EX gets bubble (sel=0).
//     rst mid-sequence -> all sels 0, stall_cnt=0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants for the EX-stage forwarding/hazard unit.
package pipe_pkg;
    localparam int SEL_REGFILE = 0;
    localparam int LAT_ALU     = 1;
    localparam int LAT_LOAD    = 2;
    localparam int STG_EX      = 0;
    localparam int STG_MEM     = 1;
    localparam int STG_WB      = 2;

    // A latency of zero behaves exactly like a single-cycle ALU result.
    function automatic int eff_lat(input int lat);
        return (lat == 0) ? LAT_ALU : lat;
    endfunction
endpackage

// File: rtl/fwd_match.sv
// Youngest-match priority encoder for one source operand against the in-flight
// producers that can still forward; reports the stage it reaches next and readiness.
module fwd_match
    import pipe_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int AW     = 5,
    parameter int LATW   = 2,
    parameter int SELW   = $clog2(NSTAGE)
) (
    input  logic                       rs_used,
    input  logic [AW-1:0]              rs_addr,
    input  logic [NSTAGE-2:0]          ent_valid,
    input  logic [(NSTAGE-1)*AW-1:0]   ent_rd,
    input  logic [(NSTAGE-1)*LATW-1:0] ent_lat,
    output logic                       hit,
    output logic [SELW-1:0]            idx,
    output logic                       ready
);
    always_comb begin
        hit   = 1'b0;
        idx   = '0;
        ready = 1'b0;
        // Scan oldest first so the youngest matching producer overwrites older ones.
        for (int j = NSTAGE - 2; j >= 0; j--) begin
            if (rs_used && ent_valid[j] && (ent_rd[j*AW +: AW] == rs_addr)) begin
                hit   = 1'b1;
                idx   = SELW'(j + 1);
                ready = (eff_lat(int'(ent_lat[j*LATW +: LATW])) <= (j + 1));
            end
        end
    end
endmodule

// File: rtl/fwd_scoreboard.sv
// EX-stage forwarding/hazard unit: tracks write-back producers in flight, chooses EX
// operand sources one cycle early and stalls ID on results that are not yet available.
module fwd_scoreboard
    import pipe_pkg::*;
#(
    parameter int  NSRC   = 2,
    parameter int  NSTAGE = 3,
    parameter int  AW     = 5,
    parameter int  LATW   = 2,
    localparam int SELW   = $clog2(NSTAGE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    input  logic                   flush,
    input  logic                   id_valid,
    input  logic [NSRC*AW-1:0]     id_rs_addr,
    input  logic [NSRC-1:0]        id_rs_used,
    input  logic [AW-1:0]          id_rd_addr,
    input  logic                   id_reg_write,
    input  logic [LATW-1:0]        id_lat,
    output logic                   stall,
    output logic [NSRC*SELW-1:0]   fwd_sel_ex,
    output logic [31:0]            stall_cnt
);
    // The WB-stage producer is never a forwarding source (regfile is write-first),
    // so only EX..NSTAGE-2 are kept; the shift out of the last slot is retirement.
    localparam int NENT = NSTAGE - 1;

    logic [NENT-1:0]      valid_q, valid_d;
    logic [NENT*AW-1:0]   rd_q, rd_d;
    logic [NENT*LATW-1:0] lat_q, lat_d;
    logic [NSRC*SELW-1:0] sel_q, sel_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [NSRC-1:0]      hit, ready, hazard;
    logic [NSRC*SELW-1:0] idx;
    logic                 bubble;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            fwd_match #(
                .NSTAGE (NSTAGE),
                .AW     (AW),
                .LATW   (LATW),
                .SELW   (SELW)
            ) u_match (
                .rs_used   (id_rs_used[gi]),
                .rs_addr   (id_rs_addr[gi*AW +: AW]),
                .ent_valid (valid_q),
                .ent_rd    (rd_q),
                .ent_lat   (lat_q),
                .hit       (hit[gi]),
                .idx       (idx[gi*SELW +: SELW]),
                .ready     (ready[gi])
            );
            assign hazard[gi] = hit[gi] & ~ready[gi];
            assign sel_d[gi*SELW +: SELW] = (bubble || !hit[gi]) ? SELW'(SEL_REGFILE)
                                                                  : idx[gi*SELW +: SELW];
        end
    endgenerate

    assign stall  = !rst && id_valid && !flush && (|hazard);
    assign bubble = stall || flush || !id_valid;

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        if (!hold) begin
            for (int k = NENT - 1; k > 0; k--) begin
                valid_d[k]              = valid_q[k-1];
                rd_d[k*AW +: AW]        = rd_q[(k-1)*AW +: AW];
                lat_d[k*LATW +: LATW]   = lat_q[(k-1)*LATW +: LATW];
            end
            valid_d[STG_EX]               = !bubble && id_reg_write && (id_rd_addr != '0);
            rd_d[STG_EX*AW +: AW]         = id_rd_addr;
            lat_d[STG_EX*LATW +: LATW]    = id_lat;
            if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rd_q    <= '0;
            lat_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            if (!hold) begin
                sel_q <= sel_d;
            end
        end
    end

    assign fwd_sel_ex = sel_q;
    assign stall_cnt  = cnt_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: expected EX operand selects are queued at issue
// and popped when the instruction reaches EX; stall cycles and counter checked inline.
module tb_fwd_scoreboard;
    localparam int NSRC = 2, NSTAGE = 3, AW = 5, LATW = 2, SELW = 2;

    logic                 clk = 1'b0;
    logic                 rst, hold, flush, id_valid;
    logic [NSRC*AW-1:0]   id_rs_addr;
    logic [NSRC-1:0]      id_rs_used;
    logic [AW-1:0]        id_rd_addr;
    logic                 id_reg_write;
    logic [LATW-1:0]      id_lat;
    logic                 stall;
    logic [NSRC*SELW-1:0] fwd_sel_ex;
    logic [31:0]          stall_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;
    logic [NSRC*SELW-1:0] exp_q[$];

    always #5 clk = ~clk;

    fwd_scoreboard #(.NSRC(NSRC), .NSTAGE(NSTAGE), .AW(AW), .LATW(LATW)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_rs_addr   (id_rs_addr),
        .id_rs_used   (id_rs_used),
        .id_rd_addr   (id_rd_addr),
        .id_reg_write (id_reg_write),
        .id_lat       (id_lat),
        .stall        (stall),
        .fwd_sel_ex   (fwd_sel_ex),
        .stall_cnt    (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                          input logic [1:0] used, input logic [4:0] rd, input logic we,
                          input logic [1:0] lat);
        id_valid     = v;
        id_rs_addr   = {rs1, rs0};
        id_rs_used   = used;
        id_rd_addr   = rd;
        id_reg_write = we;
        id_lat       = lat;
    endtask

    task automatic set_idle();
        set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0);
    endtask

    task automatic pop_check(input string tag);
        logic [NSRC*SELW-1:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sel"}, fwd_sel_ex, e);
        end
    endtask

    // Present one instruction, count stall cycles until it enters EX, then check selects.
    task automatic issue(input string tag, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] used, input logic [4:0] rd, input logic we,
                         input logic [1:0] lat, input int exp_st,
                         input logic [1:0] s0, input logic [1:0] s1);
        int n = 0;
        @(negedge clk);
        set_id(1'b1, rs0, rs1, used, rd, we, lat);
        #1;
        while (stall === 1'b1 && n < 6) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk({tag, "_stalls"}, n, exp_st);
        exp_q.push_back({s1, s0});
        @(posedge clk);
        #1;
        exp_cnt += exp_st;
        pop_check(tag);
        chk({tag, "_cnt"}, stall_cnt, exp_cnt);
        set_idle();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sel", fwd_sel_ex, 0);
        chk("reset_cnt", stall_cnt, 0);
        chk("reset_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back ALU forwarding from MEM
        issue("t1_add", 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 2'd1, 0, 2'd0, 2'd0);
        issue("t1_sub", 5'd5, 5'd7, 2'b11, 5'd6, 1'b1, 2'd1, 0, 2'd1, 2'd0);
        idle(3);

        // Load-use: one stall, then both operands from WB
        issue("t2_lw",  5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 2'd2, 0, 2'd0, 2'd0);
        issue("t2_add", 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 2'd1, 1, 2'd2, 2'd2);
        idle(3);

        // Youngest producer wins; x0 source never forwards
        issue("t3_a",   5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 2'd1, 0, 2'd0, 2'd0);
        issue("t3_b",   5'd2, 5'd0, 2'b01, 5'd5, 1'b1, 2'd1, 0, 2'd0, 2'd0);
        issue("t3_c",   5'd5, 5'd0, 2'b11, 5'd8, 1'b1, 2'd1, 0, 2'd1, 2'd0);
        idle(3);

        // Youngest unready load shadows an older ready ALU result
        issue("t3b_a",  5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 2'd1, 0, 2'd0, 2'd0);
        issue("t3b_lw", 5'd3, 5'd0, 2'b01, 5'd5, 1'b1, 2'd2, 0, 2'd0, 2'd0);
        issue("t3b_c",  5'd5, 5'd4, 2'b11, 5'd9, 1'b1, 2'd1, 1, 2'd2, 2'd0);
        idle(3);

        // x0 destination, unused operands, and non-writing producers
        issue("t4_x0w", 5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 2'd2, 0, 2'd0, 2'd0);
        issue("t4_x0r", 5'd0, 5'd0, 2'b11, 5'd6, 1'b1, 2'd1, 0, 2'd0, 2'd0);
        issue("t4_lw9", 5'd1, 5'd0, 2'b01, 5'd9, 1'b1, 2'd2, 0, 2'd0, 2'd0);
        issue("t4_unu", 5'd9, 5'd9, 2'b00, 5'd13, 1'b1, 2'd1, 0, 2'd0, 2'd0);
        issue("t4_nwe", 5'd1, 5'd0, 2'b01, 5'd12, 1'b0, 2'd2, 0, 2'd0, 2'd0);
        issue("t4_use", 5'd12, 5'd12, 2'b11, 5'd14, 1'b1, 2'd1, 0, 2'd0, 2'd0);
        idle(3);

        // lat=0 acts like ALU; lat=3 never forwards and waits for retirement
        issue("t7_lat0", 5'd1, 5'd0, 2'b01, 5'd10, 1'b1, 2'd0, 0, 2'd0, 2'd0);
        issue("t7_use0", 5'd10, 5'd0, 2'b01, 5'd6, 1'b1, 2'd1, 0, 2'd1, 2'd0);
        idle(3);
        issue("t7_lat3", 5'd1, 5'd0, 2'b01, 5'd11, 1'b1, 2'd3, 0, 2'd0, 2'd0);
        issue("t7_use3", 5'd11, 5'd0, 2'b01, 5'd6, 1'b1, 2'd1, 2, 2'd0, 2'd0);
        idle(3);

        // hold for three cycles during a load-use stall
        issue("t5_add", 5'd1, 5'd0, 2'b01, 5'd3, 1'b1, 2'd1, 0, 2'd0, 2'd0);
        issue("t5_lw",  5'd3, 5'd0, 2'b01, 5'd5, 1'b1, 2'd2, 0, 2'd1, 2'd0);
        @(negedge clk);
        set_id(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 2'd1);
        hold = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("t5_hold_stall", stall, 1);
            chk("t5_hold_sel", fwd_sel_ex, 4'b0001);
            chk("t5_hold_cnt", stall_cnt, exp_cnt);
            @(negedge clk);
            #1;
        end
        hold = 1'b0;
        #1;
        chk("t5_post_stall", stall, 1);
        @(posedge clk);
        #1;
        exp_cnt += 1;
        chk("t5_post_cnt", stall_cnt, exp_cnt);
        chk("t5_bubble_sel", fwd_sel_ex, 0);
        @(negedge clk);
        #1;
        chk("t5_go_stall", stall, 0);
        exp_q.push_back({2'd2, 2'd2});
        @(posedge clk);
        #1;
        pop_check("t5_use");
        set_idle();
        idle(3);

        // flush with a hazard in ID
        issue("t6_lw", 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 2'd2, 0, 2'd0, 2'd0);
        @(negedge clk);
        set_id(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 2'd1);
        flush = 1'b1;
        #1;
        chk("t6_flush_stall", stall, 0);
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        pop_check("t6_flush");
        chk("t6_flush_cnt", stall_cnt, exp_cnt);
        flush = 1'b0;
        set_idle();
        issue("t6_after", 5'd5, 5'd0, 2'b01, 5'd7, 1'b1, 2'd1, 0, 2'd2, 2'd0);
        idle(3);

        // reset in the middle of a load-use stall
        issue("t8_add", 5'd1, 5'd0, 2'b01, 5'd3, 1'b1, 2'd1, 0, 2'd0, 2'd0);
        issue("t8_lw",  5'd3, 5'd0, 2'b01, 5'd5, 1'b1, 2'd2, 0, 2'd1, 2'd0);
        @(negedge clk);
        set_id(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 2'd1);
        #1;
        chk("t8_pre_rst_stall", stall, 1);
        rst = 1'b1;
        #1;
        chk("t8_rst_stall", stall, 0);
        @(posedge clk);
        #1;
        exp_cnt = 0;
        chk("t8_rst_sel", fwd_sel_ex, 0);
        chk("t8_rst_cnt", stall_cnt, exp_cnt);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t8_retry_stall", stall, 0);
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        pop_check("t8_retry");
        chk("t8_retry_cnt", stall_cnt, exp_cnt);
        set_idle();
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
